// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch, decode, execute,
// memory and writeback one state per clock and drives every datapath select.
module multicycle_control #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [6:0]         opcode,
   output logic               pc_write,
   output logic               pc_write_cond,
   output logic [1:0]         pc_source,
   output logic               iord,
   output logic               mem_read,
   output logic               mem_write,
   output logic               ir_write,
   output logic [1:0]         mem_to_reg,
   output logic               reg_write,
   output logic [1:0]         alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         alu_op,
   output logic               instr_done,
   output logic [STATE_W-1:0] state
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [STATE_W-1:0] {
      FETCH    = STATE_W'(0),
      DECODE   = STATE_W'(1),
      MEMADR   = STATE_W'(2),
      MEMREAD  = STATE_W'(3),
      MEMWB    = STATE_W'(4),
      MEMWRITE = STATE_W'(5),
      EXEC_R   = STATE_W'(6),
      EXEC_I   = STATE_W'(7),
      ALUWB    = STATE_W'(8),
      BRANCH   = STATE_W'(9),
      JAL      = STATE_W'(10)
   } stateT;

   stateT currentState;
   stateT nextState;
   logic  isLoad;

   // isLoad remembers the load/store choice so MEMADR never looks at opcode again
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         currentState <= FETCH;
         isLoad       <= 1'b0;
      end else begin
         currentState <= nextState;
         if (currentState == DECODE) begin
            isLoad <= (opcode == OP_LOAD);
         end
      end
   end

   always_comb begin
      nextState     = FETCH;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 2'b00;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 2'b00;
      reg_write     = 1'b0;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      instr_done    = 1'b0;
      case (currentState)
         FETCH: begin
            mem_read  = 1'b1;
            ir_write  = 1'b1;
            alu_src_b = 2'b01;
            pc_write  = 1'b1;
            nextState = DECODE;
         end
         DECODE: begin
            alu_src_b = 2'b10;
            case (opcode)
               OP_LOAD, OP_STORE: nextState = MEMADR;
               OP_RTYPE:          nextState = EXEC_R;
               OP_ITYPE:          nextState = EXEC_I;
               OP_BRANCH:         nextState = BRANCH;
               OP_JAL:            nextState = JAL;
               default:           instr_done = 1'b1;
            endcase
         end
         MEMADR: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            nextState = isLoad ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            mem_read  = 1'b1;
            iord      = 1'b1;
            nextState = MEMWB;
         end
         MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 2'b01;
            instr_done = 1'b1;
         end
         MEMWRITE: begin
            mem_write  = 1'b1;
            iord       = 1'b1;
            instr_done = 1'b1;
         end
         EXEC_R: begin
            alu_src_a = 2'b01;
            alu_op    = 2'b10;
            nextState = ALUWB;
         end
         EXEC_I: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            alu_op    = 2'b11;
            nextState = ALUWB;
         end
         ALUWB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         BRANCH: begin
            alu_src_a     = 2'b01;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
            instr_done    = 1'b1;
         end
         JAL: begin
            // PC already advanced to PC+4 in FETCH, so that is the link value
            pc_write   = 1'b1;
            pc_source  = 2'b01;
            reg_write  = 1'b1;
            mem_to_reg = 2'b10;
            instr_done = 1'b1;
         end
         default: ;
      endcase
   end

   assign state = currentState;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: directed instruction sequences plus randomized
// opcodes and reset pulses, checked every cycle against a path-queue model.
module tb_multicycle_control;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [17:0] CTRL_FETCH = 18'b1_0_00_0_1_0_1_00_0_00_01_00_0;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] opcode;
   logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
   logic       reg_write, instr_done;
   logic [1:0] pc_source, mem_to_reg, alu_src_a, alu_src_b, alu_op;
   logic [3:0] state;
   logic [17:0] ctrl;

   multicycle_control #(.STATE_W(4)) dut (
      .clk(clk), .reset(reset), .opcode(opcode),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
      .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .instr_done(instr_done), .state(state)
   );

   always #5 clk = ~clk;

   assign ctrl = {pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, instr_done};

   int checks = 0;
   int passes = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic bit isUnknown(input logic [6:0] op);
      return !(op inside {OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL});
   endfunction

   function automatic int latOf(input logic [6:0] op);
      case (op)
         OP_LOAD:                      return 5;
         OP_STORE, OP_RTYPE, OP_ITYPE: return 4;
         OP_BRANCH, OP_JAL:            return 3;
         default:                      return 2;
      endcase
   endfunction

   // Control word each step must show, instr_done excluded (the path model supplies it)
   function automatic logic [17:0] tableCtrl(input logic [3:0] st);
      case (st)
         4'd0:    return CTRL_FETCH;
         4'd1:    return 18'b0_0_00_0_0_0_0_00_0_00_10_00_0;
         4'd2:    return 18'b0_0_00_0_0_0_0_00_0_01_10_00_0;
         4'd3:    return 18'b0_0_00_1_1_0_0_00_0_00_00_00_0;
         4'd4:    return 18'b0_0_00_0_0_0_0_01_1_00_00_00_0;
         4'd5:    return 18'b0_0_00_1_0_1_0_00_0_00_00_00_0;
         4'd6:    return 18'b0_0_00_0_0_0_0_00_0_01_00_10_0;
         4'd7:    return 18'b0_0_00_0_0_0_0_00_0_01_10_11_0;
         4'd8:    return 18'b0_0_00_0_0_0_0_00_1_00_00_00_0;
         4'd9:    return 18'b0_1_01_0_0_0_0_00_0_01_00_01_0;
         4'd10:   return 18'b1_0_01_0_0_0_0_10_1_00_00_00_0;
         default: return 18'b0;
      endcase
   endfunction

   // Model: after DECODE the whole remaining path of the instruction is queued, ending in FETCH
   logic [3:0] mExp = 4'd0;
   logic [6:0] mOp  = 7'd0;
   int         q[$];
   bit         checkEn = 1'b0;
   int         dutCyc = 0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mExp = 4'd0;
         q.delete();
      end else begin
         if (mExp == 4'd1) begin
            mOp = opcode;
            q.delete();
            case (opcode)
               OP_LOAD:   begin q.push_back(2); q.push_back(3); q.push_back(4); end
               OP_STORE:  begin q.push_back(2); q.push_back(5); end
               OP_RTYPE:  begin q.push_back(6); q.push_back(8); end
               OP_ITYPE:  begin q.push_back(7); q.push_back(8); end
               OP_BRANCH: q.push_back(9);
               OP_JAL:    q.push_back(10);
               default:   ;
            endcase
            q.push_back(0);
         end
         if (mExp == 4'd0) mExp = 4'd1;
         else if (q.size() > 0) mExp = 4'(q.pop_front());
         else mExp = 4'd0;
      end
   end

   always @(negedge clk) begin : compare
      bit expDone;
      if (checkEn && !reset) begin
         expDone = (mExp == 4'd1) ? isUnknown(opcode) : ((mExp != 4'd0) && (q.size() == 1));
         dutCyc  = (state == 4'd0) ? 1 : dutCyc + 1;
         checkOutput("state", 32'(state), 32'(mExp));
         checkOutput("controls", 32'(ctrl), 32'(tableCtrl(mExp) | 18'(expDone)));
         checkOutput("pcWriteExclusive", 32'(pc_write & pc_write_cond), 32'd0);
         checkOutput("memExclusive", 32'(mem_read & mem_write), 32'd0);
         if (instr_done)
            checkOutput("latency", 32'(dutCyc), 32'(latOf((mExp == 4'd1) ? opcode : mOp)));
      end
   end

   logic [31:0] seqWord, doneWord, regWWord, memWWord;
   logic [17:0] ctrlAtDone;

   task automatic record();
      seqWord  = {seqWord[27:0], state};
      doneWord = {doneWord[30:0], instr_done};
      regWWord = {regWWord[30:0], reg_write};
      memWWord = {memWWord[30:0], mem_write};
      if (instr_done) ctrlAtDone = ctrl;
   endtask

   task automatic waitFetch();
      int guard = 0;
      while (mExp != 4'd0 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) checkOutput("fetchTimeout", 32'(guard), 32'd0);
   endtask

   // Runs one instruction from FETCH back to FETCH, optionally scrambling opcode after DECODE
   task automatic applyStimulus(input logic [6:0] op, input bit scramble, input logic [6:0] scrOp);
      int steps = 0;
      waitFetch();
      opcode = op;
      seqWord = '0; doneWord = '0; regWWord = '0; memWWord = '0; ctrlAtDone = '0;
      record();
      do begin
         @(negedge clk);
         record();
         steps++;
         if (scramble && state != 4'd0 && state != 4'd1) opcode = scrOp;
      end while (state != 4'd0 && steps < 12);
      if (steps >= 12) checkOutput("instrTimeout", 32'(steps), 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [6:0] ops[6];
      logic [6:0] op;
      int guard;
      ops = '{OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL};
      reset  = 1'b1;
      opcode = 7'd0;
      repeat (2) @(negedge clk);
      checkOutput("resetState", 32'(state), 32'd0);
      checkOutput("resetFetchCtrl", 32'(ctrl), 32'(CTRL_FETCH));
      reset   = 1'b0;
      checkEn = 1'b1;

      applyStimulus(OP_LOAD, 1'b0, 7'd0);
      checkOutput("loadSeq", seqWord, 32'h012340);
      checkOutput("loadDone", doneWord, 32'b000010);
      checkOutput("loadRegWrite", regWWord, 32'b000010);
      checkOutput("loadWbCtrl", 32'(ctrlAtDone), 32'(18'b0_0_00_0_0_0_0_01_1_00_00_00_1));
      applyStimulus(OP_LOAD, 1'b0, 7'd0);
      checkOutput("loadSeqRepeat", seqWord, 32'h012340);

      applyStimulus(OP_STORE, 1'b1, OP_RTYPE);
      checkOutput("storeSeq", seqWord, 32'h01250);
      checkOutput("storeMemWrite", memWWord, 32'b00010);
      checkOutput("storeCtrl", 32'(ctrlAtDone), 32'(18'b0_0_00_1_0_1_0_00_0_00_00_00_1));

      applyStimulus(OP_BRANCH, 1'b0, 7'd0);
      checkOutput("branchSeq", seqWord, 32'h0190);
      checkOutput("branchCtrl", 32'(ctrlAtDone), 32'(18'b0_1_01_0_0_0_0_00_0_01_00_01_1));

      applyStimulus(OP_JAL, 1'b0, 7'd0);
      checkOutput("jalSeq", seqWord, 32'h01A0);
      checkOutput("jalCtrl", 32'(ctrlAtDone), 32'(18'b1_0_01_0_0_0_0_10_1_00_00_00_1));

      applyStimulus(7'b1111111, 1'b0, 7'd0);
      checkOutput("nopSeq", seqWord, 32'h010);
      checkOutput("nopDone", doneWord, 32'b010);
      checkOutput("nopRegWrite", regWWord, 32'd0);
      checkOutput("nopMemWrite", memWWord, 32'd0);

      // Asynchronous reset in the middle of EXEC_R
      waitFetch();
      opcode = OP_RTYPE;
      guard  = 0;
      while (state != 4'd6 && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("reachExecR", 32'(state), 32'd6);
      #2 reset = 1'b1;
      #1;
      checkOutput("resetAsyncState", 32'(state), 32'd0);
      checkOutput("resetAsyncCtrl", 32'(ctrl), 32'(CTRL_FETCH));
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("afterResetDecode", 32'(state), 32'd1);

      for (int i = 0; i < 300; i++) begin
         op = ($urandom_range(0, 5) == 0) ? 7'($urandom) : ops[$urandom_range(0, 5)];
         if ($urandom_range(0, 9) == 0) begin
            waitFetch();
            opcode = op;
            repeat ($urandom_range(1, 4)) @(negedge clk);
            #2 reset = 1'b1;
            #4 reset = 1'b0;
            @(negedge clk);
         end else begin
            applyStimulus(op, 1'($urandom_range(0, 1)), 7'($urandom));
         end
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
